// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the 32-bit MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath
// select. Fetch and load reads are stretched to MEM_LAT cycles by a counter.
module mc_ctrl_fsm #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_EXEC_I   = 4'd5,
    S_IMM_WB   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_e;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_done;
  logic [2:0]       r_alu_op;
  logic             r_funct_ok;
  logic             pc_write, pc_write_cond;

  assign cnt_done = (cnt_q == CNT_LAST);

  // R-type funct decode; an unknown funct yields no ALU op and a trap
  always_comb begin
    r_alu_op   = OP_NONE;
    r_funct_ok = 1'b1;
    case (funct)
      6'h20:   r_alu_op = OP_ADD;
      6'h22:   r_alu_op = OP_SUB;
      6'h24:   r_alu_op = OP_AND;
      6'h25:   r_alu_op = OP_OR;
      6'h2A:   r_alu_op = OP_SLT;
      default: r_funct_ok = 1'b0;
    endcase
  end

  // State and wait-counter registers; async reset aborts any instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; counter only advances inside the two memory-read states
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (cnt_done) state_d = S_DECODE;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_DECODE: begin
        case (opcode)
          6'h00:        state_d = S_EXEC_R;
          6'h08:        state_d = S_EXEC_I;
          6'h23, 6'h2B: state_d = S_MEM_ADDR;
          6'h04:        state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_d = r_funct_ok ? S_ALU_WB : S_TRAP;
      S_EXEC_I:   state_d = S_IMM_WB;
      S_MEM_ADDR: state_d = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (cnt_done) state_d = S_MEM_WB;
        else          cnt_d   = cnt_q + 1'b1;
      end
      S_ALU_WB, S_IMM_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP:
                  state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // Moore output decode from state and counter
  always_comb begin
    iord          = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = OP_NONE;
    pc_source     = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = OP_ADD;
        ir_write  = cnt_done;
        pc_write  = cnt_done;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = OP_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = r_alu_op;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = OP_ADD;
      end
      S_IMM_WB: reg_write = 1'b1;
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign pc_en     = pc_write | (pc_write_cond & zero);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: a stimulus process expands each random
// instruction into its per-cycle phase list and queues the expected outputs;
// a monitor on the falling edge pops and compares against the DUT.
module tb_mc_ctrl_fsm;
  localparam int LAT = 2;

  // Phase ids follow the documented state_dbg encoding
  localparam int P_RESET = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC_R = 3,
                 P_ALU_WB = 4, P_EXEC_I = 5, P_IMM_WB = 6, P_MEM_ADDR = 7,
                 P_MEM_RD = 8, P_MEM_WB = 9, P_MEM_WR = 10, P_BRANCH = 11,
                 P_JUMP = 12, P_TRAP = 13;

  typedef struct packed {
    logic       illegal;
    logic [3:0] st;
    logic       pc_en, iord, mem_rd, mem_wr, ir_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
  } ov_t;

  logic clk = 1'b0, reset_n = 1'b0, zero = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic pc_en, iord, mem_rd, mem_wr, ir_write, reg_write, reg_dst, mem_to_reg;
  logic alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  int   n_vec = 0, n_bad = 0;
  ov_t  expq[$];

  mc_ctrl_fsm #(.MEM_LAT(LAT), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal(illegal),
    .state_dbg(state_dbg));

  always #5 clk = ~clk;

  function automatic ov_t act_vec();
    ov_t a;
    a = '{illegal, state_dbg, pc_en, iord, mem_rd, mem_wr, ir_write, reg_write,
          reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
    return a;
  endfunction

  // R-type ALU operation by funct; 0 means the funct is unsupported
  function automatic logic [2:0] r_op(logic [5:0] fn);
    case (fn)
      6'h20: return 3'b001;
      6'h22: return 3'b010;
      6'h24: return 3'b011;
      6'h25: return 3'b100;
      6'h2A: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle spent in a given phase
  function automatic ov_t exp_vec(int ph, bit last, logic z, logic [5:0] fn);
    ov_t o = '0;
    o.st = 4'(ph);
    case (ph)
      P_FETCH:    begin o.mem_rd = 1; o.srcb = 1; o.aluop = 1;
                        o.ir_write = last; o.pc_en = last; end
      P_DECODE:   begin o.srcb = 3; o.aluop = 1; end
      P_EXEC_R:   begin o.alu_src_a = 1; o.aluop = r_op(fn); end
      P_ALU_WB:   begin o.reg_write = 1; o.reg_dst = 1; end
      P_EXEC_I, P_MEM_ADDR: begin o.alu_src_a = 1; o.srcb = 2; o.aluop = 1; end
      P_IMM_WB:   o.reg_write = 1;
      P_MEM_RD:   begin o.mem_rd = 1; o.iord = 1; end
      P_MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 1; end
      P_MEM_WR:   begin o.mem_wr = 1; o.iord = 1; end
      P_BRANCH:   begin o.alu_src_a = 1; o.aluop = 2; o.pcsrc = 1; o.pc_en = z; end
      P_JUMP:     begin o.pc_en = 1; o.pcsrc = 2; end
      P_TRAP:     o.illegal = 1;
      default:    ;
    endcase
    return o;
  endfunction

  task automatic chk(string name, ov_t act, ov_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %h want %h (state got %0d want %0d)",
               name, $time, act, exp, act.st, exp.st);
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle
  initial forever begin
    @(negedge clk);
    if (expq.size() > 0) chk("cycle", act_vec(), expq.pop_front());
  end

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset_n = 1'b0;
      expq.push_back(exp_vec(P_RESET, 0, 0, 0));
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    expq.push_back(exp_vec(P_RESET, 0, 0, 0));
  endtask

  // zmode: 0 random zero, 1 force zero=1, 2 force zero=0
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int zmode,
                           int trap_hold, bit abort_in_rd);
    int ph[$];
    bit lst[$];
    for (int i = 0; i < LAT; i++) begin ph.push_back(P_FETCH); lst.push_back(i == LAT-1); end
    ph.push_back(P_DECODE); lst.push_back(0);
    case (op)
      6'h00: begin
        ph.push_back(P_EXEC_R); lst.push_back(0);
        if (r_op(fn) != 0) begin ph.push_back(P_ALU_WB); lst.push_back(0); end
        else for (int i = 0; i < trap_hold; i++) begin ph.push_back(P_TRAP); lst.push_back(0); end
      end
      6'h08: begin ph.push_back(P_EXEC_I); ph.push_back(P_IMM_WB); lst.push_back(0); lst.push_back(0); end
      6'h23: begin
        ph.push_back(P_MEM_ADDR); lst.push_back(0);
        for (int i = 0; i < LAT; i++) begin ph.push_back(P_MEM_RD); lst.push_back(i == LAT-1); end
        ph.push_back(P_MEM_WB); lst.push_back(0);
      end
      6'h2B: begin ph.push_back(P_MEM_ADDR); ph.push_back(P_MEM_WR); lst.push_back(0); lst.push_back(0); end
      6'h04: begin ph.push_back(P_BRANCH); lst.push_back(0); end
      6'h02: begin ph.push_back(P_JUMP); lst.push_back(0); end
      default: for (int i = 0; i < trap_hold; i++) begin ph.push_back(P_TRAP); lst.push_back(0); end
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      @(posedge clk); #1;
      opcode = op;
      funct  = fn;
      zero   = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom);
      if (abort_in_rd && ph[i] == P_MEM_RD) begin
        // Reset mid-read: strobes must drop with no clock edge
        chk("memrd_before_abort", act_vec(), exp_vec(P_MEM_RD, 0, zero, fn));
        reset_n = 1'b0;
        #1;
        chk("abort_async", act_vec(), exp_vec(P_RESET, 0, 0, 0));
        expq.push_back(exp_vec(P_RESET, 0, 0, 0));
        return;
      end
      expq.push_back(exp_vec(ph[i], lst[i], zero, fn));
    end
  endtask

  task automatic run_random(int n);
    logic [5:0] ops [6] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < n; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 5)];
      fn = (op == 6'h00) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(op, fn, 0, 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    run_instr(6'h00, 6'h22, 0, 0, 0);   // sub
    run_instr(6'h23, 6'h00, 0, 0, 0);   // lw
    run_instr(6'h2B, 6'h00, 0, 0, 0);   // sw
    run_instr(6'h04, 6'h00, 1, 0, 0);   // beq taken
    run_instr(6'h04, 6'h00, 2, 0, 0);   // beq not taken
    run_instr(6'h02, 6'h00, 0, 0, 0);   // j
    run_random(40);
    run_instr(6'h3F, 6'h00, 0, 22, 0);  // illegal opcode
    do_reset(1);
    run_instr(6'h00, 6'h07, 0, 22, 0);  // illegal funct
    do_reset(2);
    run_random(5);
    run_instr(6'h23, 6'h00, 0, 0, 1);   // lw aborted in MEM_RD
    do_reset(2);
    run_random(20);
    run_instr(6'($urandom_range(9, 15)), 6'h00, 0, 21, 0);
    do_reset(1);
    run_random(5);
    repeat (2) @(negedge clk);
    n_vec++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
